// File: rtl/sc_spi_xfer_buf.sv
// Transfer buffer and start/complete sequencer in front of the SPI engine.
// It holds a 16x32 TX buffer and a 16x32 RX buffer and a host word port, all in the SPICLK domain.
module sc_spi_xfer_buf #(
   parameter bit RXCLR = 1'b1
) (
   input  logic        SPICLK,
   input  logic        SYSRSTB,
   input  logic        HWE,
   input  logic        HRE,
   input  logic [4:0]  HADDR,
   input  logic [31:0] HWDATA,
   output logic [31:0] HRDATA,
   input  logic        XSTART,
   input  logic        XDONECLR,
   output logic        XBUSY,
   output logic        XDONE,
   output logic        WERR,
   output logic [4:0]  RXCNT,
   output logic        SPISTART,
   input  logic        SPIBUSY,
   input  logic [3:0]  TXDPT,
   output logic [31:0] TXDATA,
   input  logic [31:0] RXDATA,
   input  logic        RXVALID,
   input  logic [3:0]  RXDPT
);

   typedef enum logic [2:0] {S_IDLE, S_START, S_ACK, S_WAIT, S_DRAIN} state_t;

   state_t      state, state_nxt;
   logic [1:0]  ack_cnt, ack_cnt_nxt;
   logic        done_set, start_go, timeout;
   logic        tx_wr, werr_set, rx_cap, rx_clr;
   logic [31:0] txbuf [16];
   logic [31:0] rxbuf [16];

   always_comb begin
      state_nxt   = state;
      ack_cnt_nxt = ack_cnt;
      done_set    = 1'b0;
      start_go    = 1'b0;
      timeout     = 1'b0;
      case (state)
         S_IDLE: begin
            if (XSTART) begin
               state_nxt = S_START;
               start_go  = 1'b1;
            end
         end
         S_START: begin
            state_nxt   = S_ACK;
            ack_cnt_nxt = 2'd0;
         end
         // Give the engine three cycles to show SPIBUSY before giving up.
         S_ACK: begin
            if (SPIBUSY) begin
               state_nxt = S_WAIT;
            end else if (ack_cnt == 2'd2) begin
               state_nxt = S_IDLE;
               done_set  = 1'b1;
               timeout   = 1'b1;
            end else begin
               ack_cnt_nxt = ack_cnt + 2'd1;
            end
         end
         S_WAIT: begin
            if (!SPIBUSY) state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            state_nxt = S_IDLE;
            done_set  = 1'b1;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge SPICLK or negedge SYSRSTB) begin
      if (!SYSRSTB) begin
         state    <= S_IDLE;
         ack_cnt  <= 2'd0;
         XBUSY    <= 1'b0;
         SPISTART <= 1'b0;
      end else begin
         state    <= state_nxt;
         ack_cnt  <= ack_cnt_nxt;
         XBUSY    <= (state_nxt != S_IDLE);
         SPISTART <= (state_nxt == S_START);
      end
   end

   assign tx_wr    = HWE & ~HADDR[4] & ~XBUSY;
   assign werr_set = HWE & ~HADDR[4] & XBUSY;
   // DRAIN still accepts a word so a last RXVALID coinciding with SPIBUSY falling is kept.
   assign rx_cap   = RXVALID & ((state == S_WAIT) | (state == S_DRAIN));
   assign rx_clr   = start_go & RXCLR;
   assign TXDATA   = txbuf[TXDPT];

   always_ff @(posedge SPICLK or negedge SYSRSTB) begin
      if (!SYSRSTB) begin
         for (int i = 0; i < 16; i++) begin
            txbuf[i] <= 32'd0;
            rxbuf[i] <= 32'd0;
         end
      end else begin
         if (tx_wr) txbuf[HADDR[3:0]] <= HWDATA;
         if (rx_clr) begin
            for (int i = 0; i < 16; i++) rxbuf[i] <= 32'd0;
         end else if (rx_cap) begin
            rxbuf[RXDPT] <= RXDATA;
         end
      end
   end

   always_ff @(posedge SPICLK or negedge SYSRSTB) begin
      if (!SYSRSTB) begin
         RXCNT  <= 5'd0;
         XDONE  <= 1'b0;
         WERR   <= 1'b0;
         HRDATA <= 32'd0;
      end else begin
         if (timeout || rx_clr)              RXCNT <= 5'd0;
         else if (rx_cap && RXCNT != 5'd16)  RXCNT <= RXCNT + 5'd1;
         if (done_set)                       XDONE <= 1'b1;
         else if (XDONECLR || start_go)      XDONE <= 1'b0;
         if (werr_set)                       WERR  <= 1'b1;
         else if (XDONECLR)                  WERR  <= 1'b0;
         if (HRE) HRDATA <= HADDR[4] ? rxbuf[HADDR[3:0]] : txbuf[HADDR[3:0]];
      end
   end

endmodule

// File: tb/tb_sc_spi_xfer_buf.sv
// Randomized bench for sc_spi_xfer_buf: the bench plays the engine and compares against buffer/flag models.
module tb_sc_spi_xfer_buf;

   localparam bit RXCLR = 1'b1;

   logic        SPICLK = 1'b0;
   logic        SYSRSTB = 1'b0;
   logic        HWE = 1'b0, HRE = 1'b0;
   logic [4:0]  HADDR = '0;
   logic [31:0] HWDATA = '0;
   logic [31:0] HRDATA;
   logic        XSTART = 1'b0, XDONECLR = 1'b0;
   logic        XBUSY, XDONE, WERR;
   logic [4:0]  RXCNT;
   logic        SPISTART;
   logic        SPIBUSY = 1'b0;
   logic [3:0]  TXDPT = '0;
   logic [31:0] TXDATA;
   logic [31:0] RXDATA = '0;
   logic        RXVALID = 1'b0;
   logic [3:0]  RXDPT = '0;

   sc_spi_xfer_buf #(.RXCLR(RXCLR)) dut (
      .SPICLK(SPICLK), .SYSRSTB(SYSRSTB), .HWE(HWE), .HRE(HRE), .HADDR(HADDR),
      .HWDATA(HWDATA), .HRDATA(HRDATA), .XSTART(XSTART), .XDONECLR(XDONECLR),
      .XBUSY(XBUSY), .XDONE(XDONE), .WERR(WERR), .RXCNT(RXCNT), .SPISTART(SPISTART),
      .SPIBUSY(SPIBUSY), .TXDPT(TXDPT), .TXDATA(TXDATA), .RXDATA(RXDATA),
      .RXVALID(RXVALID), .RXDPT(RXDPT)
   );

   always #5 SPICLK = ~SPICLK;

   // Reference state: buffer contents, capture count and sticky flags.
   logic [31:0] txm [16];
   logic [31:0] rxm [16];
   int          cnt;
   bit          done, werr;
   int          n_checks = 0, n_errors = 0;
   int          sp_cnt = 0;

   always @(posedge SPICLK) if (SPISTART) sp_cnt <= sp_cnt + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         txm[i] = '0;
         rxm[i] = '0;
      end
      cnt = 0; done = 0; werr = 0;
   endtask

   task automatic check_flags(input string tag);
      chk({tag, "_xdone"}, XDONE, done);
      chk({tag, "_werr"}, WERR, werr);
      chk({tag, "_rxcnt"}, RXCNT, cnt);
   endtask

   task automatic host_write(input logic [4:0] a, input logic [31:0] d);
      @(negedge SPICLK);
      HWE = 1'b1; HADDR = a; HWDATA = d;
      if (!a[4]) txm[a[3:0]] = d;
      @(negedge SPICLK);
      HWE = 1'b0;
   endtask

   task automatic host_read(input logic [4:0] a, input string tag);
      logic [31:0] exp;
      exp = a[4] ? rxm[a[3:0]] : txm[a[3:0]];
      @(negedge SPICLK);
      HRE = 1'b1; HADDR = a;
      @(negedge SPICLK);
      HRE = 1'b0; HADDR = a ^ 5'h10;
      chk(tag, HRDATA, exp);
      @(negedge SPICLK);
      chk({tag, "_hold"}, HRDATA, exp);
   endtask

   // Runs one transfer with the bench acting as the engine.
   task automatic xfer(input int n, input bit coincide, input bit no_busy, input int rst_after,
                       input bit wr_at_start, input bit force_wr);
      int base;
      logic [31:0] d;
      base = sp_cnt;
      @(negedge SPICLK);
      XSTART = 1'b1;
      if (wr_at_start) begin
         HWE = 1'b1; HADDR = {1'b0, 4'($urandom_range(0, 15))}; HWDATA = $urandom;
         txm[HADDR[3:0]] = HWDATA;
      end
      done = 0;
      if (RXCLR) begin
         for (int i = 0; i < 16; i++) rxm[i] = '0;
         cnt = 0;
      end
      @(negedge SPICLK);
      XSTART = 1'b0; HWE = 1'b0;
      chk("spistart_pulse", SPISTART, 1'b1);
      chk("xbusy_start", XBUSY, 1'b1);
      chk("xdone_clr_on_start", XDONE, 1'b0);
      if (no_busy) begin
         repeat (3) @(negedge SPICLK);
         chk("ack_third_cycle_busy", XBUSY, 1'b1);
         @(negedge SPICLK);
         chk("timeout_idle", XBUSY, 1'b0);
         done = 1; cnt = 0;
         check_flags("timeout");
         chk("timeout_spistart_count", sp_cnt - base, 1);
         return;
      end
      SPIBUSY = 1'b1;
      @(negedge SPICLK);
      @(negedge SPICLK);
      chk("spistart_low_in_wait", SPISTART, 1'b0);
      for (int i = 0; i < n; i++) begin
         TXDPT = 4'(i % 16);
         #1 chk("txdata", TXDATA, txm[i % 16]);
         d = $urandom;
         RXVALID = 1'b1; RXDPT = 4'(i % 16); RXDATA = d;
         rxm[i % 16] = d;
         if (cnt < 16) cnt++;
         if ($urandom_range(0, 3) == 0) XSTART = 1'b1;
         if (force_wr && i == 0 || $urandom_range(0, 3) == 0) begin
            HWE = 1'b1; HWDATA = $urandom;
            HADDR = {(force_wr && i == 0) ? 1'b0 : 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15))};
            XDONECLR = 1'($urandom_range(0, 1));
            if (!HADDR[4]) werr = 1;
            else if (XDONECLR) werr = 0;
         end
         if (i == n - 1 && coincide) SPIBUSY = 1'b0;
         @(negedge SPICLK);
         RXVALID = 1'b0; HWE = 1'b0; XSTART = 1'b0; XDONECLR = 1'b0;
         if (i == rst_after) begin
            SYSRSTB = 1'b0; SPIBUSY = 1'b0;
            #1;
            model_reset();
            chk("rst_xbusy", XBUSY, 1'b0);
            chk("rst_spistart", SPISTART, 1'b0);
            chk("rst_hrdata", HRDATA, 32'd0);
            check_flags("rst");
            @(negedge SPICLK);
            SYSRSTB = 1'b1;
            return;
         end
      end
      if (!coincide) begin
         SPIBUSY = 1'b0;
         @(negedge SPICLK);
      end
      chk("drain_busy", XBUSY, 1'b1);
      chk("drain_xdone_low", XDONE, 1'b0);
      if ($urandom_range(0, 1) == 0) begin
         XDONECLR = 1'b1;
         werr = 0;
      end
      done = 1;
      @(negedge SPICLK);
      XDONECLR = 1'b0;
      chk("end_idle", XBUSY, 1'b0);
      check_flags("end");
      chk("spistart_count", sp_cnt - base, 1);
   endtask

   task automatic clear_flags();
      @(negedge SPICLK);
      XDONECLR = 1'b1;
      @(negedge SPICLK);
      XDONECLR = 1'b0;
      done = 0; werr = 0;
      check_flags("doneclr");
   endtask

   initial begin
      model_reset();
      repeat (2) @(negedge SPICLK);
      chk("reset_xbusy", XBUSY, 1'b0);
      chk("reset_spistart", SPISTART, 1'b0);
      chk("reset_hrdata", HRDATA, 32'd0);
      check_flags("reset");
      SYSRSTB = 1'b1;

      // Two-word transfer with known TX contents.
      host_write(5'h00, 32'hA5A5_0F0F);
      host_write(5'h01, 32'h1234_5678);
      xfer(2, 1'b0, 1'b0, -1, 1'b0, 1'b0);
      host_read(5'h10, "rx0");
      host_read(5'h11, "rx1");
      host_read(5'h00, "tx0");
      host_read(5'h01, "tx1");

      // RX-region host writes are ignored without an error.
      host_write(5'h13, 32'hDEAD_BEEF);
      chk("rx_write_no_werr", WERR, 1'b0);
      host_read(5'h13, "rx3_untouched");

      for (int i = 0; i < 16; i++) host_write(5'(i), $urandom);

      // Forced busy write, then clear.
      xfer(5, 1'b0, 1'b0, -1, 1'b0, 1'b1);
      chk("werr_after_busy_write", WERR, 1'b1);
      clear_flags();

      for (int t = 0; t < 6; t++) begin
         xfer($urandom_range(1, 18), 1'($urandom_range(0, 1)), 1'b0, -1,
              1'($urandom_range(0, 1)), 1'b0);
         for (int j = 0; j < 16; j++) host_read(5'(16 + j), "rx_word");
         host_read(5'($urandom_range(0, 15)), "tx_word");
         clear_flags();
      end

      // Engine never answers.
      xfer(0, 1'b0, 1'b1, -1, 1'b0, 1'b0);
      clear_flags();

      // Reset mid-transfer, then a normal transfer.
      xfer(8, 1'b0, 1'b0, 3, 1'b0, 1'b0);
      host_read(5'h12, "rx_after_rst");
      host_read(5'h01, "tx_after_rst");
      host_write(5'h00, 32'h0BAD_F00D);
      xfer(4, 1'b1, 1'b0, -1, 1'b0, 1'b0);
      for (int j = 0; j < 4; j++) host_read(5'(16 + j), "rx_post_rst");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
